stage_ctrl_writer: RTL and testbench

//  Control-plane writer for one match-action stage: the driving end of the lookup/action-RAM write channel.

---
 rtl/stage_ctrl_writer.sv | 196 +++++++++++++++++++
 tb/tb_stage_ctrl_writer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ctrl_writer.sv
// -----------------------------------------------------------------------------
// stage_ctrl_writer
//
// Control-plane writer for one match-action stage. It reassembles config
// packets from an AXI-Stream slave into CAM key+mask entries or action words.
// Each completed entry is emitted as a one-cycle write strobe towards the
// stage's lookup CAM or action RAM. Packets addressed to other stages are
// consumed and discarded. Malformed packets are counted and never written,
// not even partially.
//
// Ports
//   axis_clk, areset    clock, synchronous active-high reset
//   c_s_axis_t*         config stream slave (tdata/tvalid/tlast in, tready out)
//   lookup_din*         CAM key, mask, entry index and write strobe
//   action_*            action word, RAM index and write strobe
//   cfg_wr_cnt          completed writes (saturating)
//   cfg_err_cnt         malformed packets (saturating)
//
// Header beat layout: [3:0] stage, [7:4] type (0 = CAM entry, 1 = action),
// [15:8] addr, [40:16] action word. A CAM packet is the header followed by
// KEY_BEATS key beats and KEY_BEATS mask beats, each LSB-first. An action
// packet is the header alone.
// -----------------------------------------------------------------------------
module stage_ctrl_writer #(
  parameter int STAGE    = 0,
  parameter int KEY_LEN  = 896,
  parameter int MASK_LEN = 896,
  parameter int CTRL_W   = 256,
  parameter int ADDR_W   = 4
) (
  input  logic                axis_clk,
  input  logic                areset,
  input  logic [CTRL_W-1:0]   c_s_axis_tdata,
  input  logic                c_s_axis_tvalid,
  input  logic                c_s_axis_tlast,
  output logic                c_s_axis_tready,
  output logic [KEY_LEN-1:0]  lookup_din,
  output logic [MASK_LEN-1:0] lookup_din_mask,
  output logic [ADDR_W-1:0]   lookup_din_addr,
  output logic                lookup_din_en,
  output logic [24:0]         action_data_in,
  output logic [ADDR_W-1:0]   action_addr,
  output logic                action_en,
  output logic [15:0]         cfg_wr_cnt,
  output logic [15:0]         cfg_err_cnt
);

  localparam int KEY_BEATS = (KEY_LEN + CTRL_W - 1) / CTRL_W;
  localparam int BUF_W     = KEY_BEATS * CTRL_W;
  // The final mask beat goes straight to the output, so only the earlier
  // beats need staging.
  localparam int MBUF_W    = BUF_W - CTRL_W;
  localparam int CNT_W     = (KEY_BEATS > 1) ? $clog2(KEY_BEATS) : 1;
  localparam int ADDR_LIM  = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KEY_BEATS - 1);
  localparam logic [3:0]       STAGE_ID  = 4'(STAGE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_MASK,
    S_COMMIT,
    S_DROP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [BUF_W-1:0]   key_buf;
  logic [MBUF_W-1:0]  mask_buf;
  logic [ADDR_W-1:0]  cam_addr;

  logic               beat;
  logic [3:0]         hdr_stage;
  logic [3:0]         hdr_type;
  logic [7:0]         hdr_addr;
  logic [24:0]        hdr_act;
  logic               hdr_addr_ok;

  assign beat        = c_s_axis_tvalid & c_s_axis_tready;
  assign hdr_stage   = c_s_axis_tdata[3:0];
  assign hdr_type    = c_s_axis_tdata[7:4];
  assign hdr_addr    = c_s_axis_tdata[15:8];
  assign hdr_act     = c_s_axis_tdata[40:16];
  assign hdr_addr_ok = int'(hdr_addr) < ADDR_LIM;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state           <= S_IDLE;
      beat_cnt        <= '0;
      c_s_axis_tready <= 1'b0;
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      lookup_din_en   <= 1'b0;
      action_data_in  <= '0;
      action_addr     <= '0;
      action_en       <= 1'b0;
      cfg_wr_cnt      <= '0;
      cfg_err_cnt     <= '0;
    end else begin
      lookup_din_en   <= 1'b0;
      action_en       <= 1'b0;
      c_s_axis_tready <= 1'b1;

      case (state)
        S_IDLE: begin
          if (beat) begin
            if (hdr_stage != STAGE_ID) begin
              // Foreign stage: silently swallow the rest of the packet.
              state <= c_s_axis_tlast ? S_IDLE : S_DROP;
            end else if (hdr_type == 4'd0 && !c_s_axis_tlast && hdr_addr_ok) begin
              cam_addr <= hdr_addr[ADDR_W-1:0];
              beat_cnt <= '0;
              state    <= S_KEY;
            end else if (hdr_type == 4'd1 && c_s_axis_tlast && hdr_addr_ok) begin
              action_data_in  <= hdr_act;
              action_addr     <= hdr_addr[ADDR_W-1:0];
              action_en       <= 1'b1;
              cfg_wr_cnt      <= sat_inc(cfg_wr_cnt);
              c_s_axis_tready <= 1'b0;
              state           <= S_COMMIT;
            end else begin
              cfg_err_cnt <= sat_inc(cfg_err_cnt);
              state       <= c_s_axis_tlast ? S_IDLE : S_DROP;
            end
          end
        end

        S_KEY: begin
          if (beat) begin
            // Shift right by one beat so the first beat ends up in the LSBs.
            key_buf <= BUF_W'({c_s_axis_tdata, key_buf} >> CTRL_W);
            if (c_s_axis_tlast) begin
              cfg_err_cnt <= sat_inc(cfg_err_cnt);
              beat_cnt    <= '0;
              state       <= S_IDLE;
            end else if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= S_MASK;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        S_MASK: begin
          if (beat) begin
            mask_buf <= MBUF_W'({c_s_axis_tdata, mask_buf} >> CTRL_W);
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if (c_s_axis_tlast) begin
                lookup_din      <= KEY_LEN'(key_buf);
                lookup_din_mask <= MASK_LEN'({c_s_axis_tdata, mask_buf});
                lookup_din_addr <= cam_addr;
                lookup_din_en   <= 1'b1;
                cfg_wr_cnt      <= sat_inc(cfg_wr_cnt);
                c_s_axis_tready <= 1'b0;
                state           <= S_COMMIT;
              end else begin
                cfg_err_cnt <= sat_inc(cfg_err_cnt);
                state       <= S_DROP;
              end
            end else if (c_s_axis_tlast) begin
              cfg_err_cnt <= sat_inc(cfg_err_cnt);
              beat_cnt    <= '0;
              state       <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        S_COMMIT: begin
          // Strobe was raised on entry; this cycle only holds off the stream.
          state <= S_IDLE;
        end

        S_DROP: begin
          if (beat && c_s_axis_tlast) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ctrl_writer.sv
// -----------------------------------------------------------------------------
// Bench for stage_ctrl_writer (instance configured as stage 2). Packets are
// classified as whole units by a reference model that pushes the expected
// writes into a queue. A monitor on the falling clock edge pops an entry for
// every write strobe the DUT raises and compares it.
// -----------------------------------------------------------------------------
module tb_stage_ctrl_writer;

  localparam int KEY_LEN  = 896;
  localparam int MASK_LEN = 896;
  localparam int CTRL_W   = 256;
  localparam int ADDR_W   = 4;
  localparam int STAGE    = 2;

  logic                clk    = 1'b0;
  logic                rst    = 1'b1;
  logic [CTRL_W-1:0]   tdata  = '0;
  logic                tvalid = 1'b0;
  logic                tlast  = 1'b0;
  logic                tready;
  logic [KEY_LEN-1:0]  lookup_din;
  logic [MASK_LEN-1:0] lookup_din_mask;
  logic [ADDR_W-1:0]   lookup_din_addr;
  logic                lookup_din_en;
  logic [24:0]         action_data_in;
  logic [ADDR_W-1:0]   action_addr;
  logic                action_en;
  logic [15:0]         cfg_wr_cnt;
  logic [15:0]         cfg_err_cnt;

  stage_ctrl_writer #(
    .STAGE(STAGE), .KEY_LEN(KEY_LEN), .MASK_LEN(MASK_LEN),
    .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)
  ) dut (
    .axis_clk(clk), .areset(rst),
    .c_s_axis_tdata(tdata), .c_s_axis_tvalid(tvalid),
    .c_s_axis_tlast(tlast), .c_s_axis_tready(tready),
    .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
    .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
    .action_data_in(action_data_in), .action_addr(action_addr),
    .action_en(action_en), .cfg_wr_cnt(cfg_wr_cnt), .cfg_err_cnt(cfg_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                  cam;
    logic [ADDR_W-1:0]   addr;
    logic [KEY_LEN-1:0]  key;
    logic [MASK_LEN-1:0] mask;
    logic [24:0]         act;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec   = 0;
  int  n_err   = 0;
  int  exp_wr  = 0;
  int  exp_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  function automatic void chk_wide(input string nm, input logic [KEY_LEN-1:0] act,
                                   input logic [KEY_LEN-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got hi %h lo %h, required hi %h lo %h", nm,
               act[KEY_LEN-1 -: 64], act[63:0], req[KEY_LEN-1 -: 64], req[63:0]);
    end
  endfunction

  function automatic logic [CTRL_W-1:0] rand_beat();
    logic [CTRL_W-1:0] r;
    for (int i = 0; i < CTRL_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Header with random filler in the ignored bits.
  function automatic logic [CTRL_W-1:0] mk_hdr(input logic [3:0] s, input logic [3:0] t,
                                               input logic [7:0] a, input logic [24:0] act);
    logic [CTRL_W-1:0] h;
    h         = rand_beat();
    h[3:0]    = s;
    h[7:4]    = t;
    h[15:8]   = a;
    h[40:16]  = act;
    return h;
  endfunction

  // Reference model: decide the fate of a complete packet from its header
  // fields and its length.
  task automatic model_pkt(input logic [CTRL_W-1:0] pk[$]);
    logic [3:0]          s, t;
    logic [7:0]          a;
    logic [4*CTRL_W-1:0] kw, mw;
    wr_t                 e;
    s = pk[0][3:0];
    t = pk[0][7:4];
    a = pk[0][15:8];
    if (s != 4'(STAGE)) return;
    if (t == 4'd1 && pk.size() == 1 && a < 8'd16) begin
      e.cam = 1'b0; e.addr = a[3:0]; e.act = pk[0][40:16];
      e.key = '0; e.mask = '0;
      exp_q.push_back(e);
      exp_wr++;
    end else if (t == 4'd0 && pk.size() == 9 && a < 8'd16) begin
      for (int k = 0; k < 4; k++) begin
        kw[k*CTRL_W +: CTRL_W] = pk[1+k];
        mw[k*CTRL_W +: CTRL_W] = pk[5+k];
      end
      e.cam = 1'b1; e.addr = a[3:0]; e.act = '0;
      e.key = KEY_LEN'(kw); e.mask = MASK_LEN'(mw);
      exp_q.push_back(e);
      exp_wr++;
    end else begin
      exp_err++;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input logic [CTRL_W-1:0] d, input bit last);
    bit acc;
    acc    = 1'b0;
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = (tready === 1'b1);
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("beat_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_pkt(input logic [CTRL_W-1:0] pk[$]);
    int g;
    model_pkt(pk);
    for (int i = 0; i < pk.size(); i++) begin
      send_beat(pk[i], i == pk.size() - 1);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #2;
    chk("cfg_wr_cnt", 64'(cfg_wr_cnt), 64'(exp_wr));
    chk("cfg_err_cnt", 64'(cfg_err_cnt), 64'(exp_err));
    chk("writes_missing", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cam_en"}, 64'(lookup_din_en), 64'd0);
    chk({tag, "_act_en"}, 64'(action_en), 64'd0);
    chk_wide({tag, "_key"}, lookup_din, '0);
    chk_wide({tag, "_mask"}, lookup_din_mask, '0);
    chk({tag, "_cam_addr"}, 64'(lookup_din_addr), 64'd0);
    chk({tag, "_act_data"}, 64'(action_data_in), 64'd0);
    chk({tag, "_act_addr"}, 64'(action_addr), 64'd0);
    chk({tag, "_wr_cnt"}, 64'(cfg_wr_cnt), 64'd0);
    chk({tag, "_err_cnt"}, 64'(cfg_err_cnt), 64'd0);
    chk({tag, "_tready"}, 64'(tready), 64'd0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && (lookup_din_en || action_en)) begin
      chk("tready_during_commit", 64'(tready), 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: cam_en %0b act_en %0b, required no strobe",
                 lookup_din_en, action_en);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_kind", 64'({lookup_din_en, action_en}), mon_e.cam ? 64'd2 : 64'd1);
        if (mon_e.cam) begin
          chk("cam_addr", 64'(lookup_din_addr), 64'(mon_e.addr));
          chk_wide("cam_key", lookup_din, mon_e.key);
          chk_wide("cam_mask", lookup_din_mask, mon_e.mask);
        end else begin
          chk("act_addr", 64'(action_addr), 64'(mon_e.addr));
          chk("act_data", 64'(action_data_in), 64'(mon_e.act));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [CTRL_W-1:0] pk[$];
    logic [CTRL_W-1:0] stale[$];
    logic [CTRL_W-1:0] b;
    int                n, stg, typ, adr, r;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // CAM entry at address 5; beat index in the low byte exposes ordering.
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd0, 8'd5, 25'd0));
    for (int k = 0; k < 4; k++) begin
      b = {64{4'hA}}; b[7:0] = 8'(k); pk.push_back(b);
    end
    for (int k = 0; k < 4; k++) begin
      b = {64{4'hF}}; b[7:0] = 8'(k); pk.push_back(b);
    end
    send_pkt(pk);

    // Single-beat action write at the top address.
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd1, 8'd15, 25'h1ABCDEF));
    send_pkt(pk);

    // Full CAM packet for stage 3: consumed, no write, no error.
    pk.delete();
    pk.push_back(mk_hdr(4'd3, 4'd0, 8'd1, 25'd0));
    for (int k = 0; k < 8; k++) pk.push_back(rand_beat());
    send_pkt(pk);

    // Short CAM packet (header + 5 beats), then a good one.
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd0, 8'd9, 25'd0));
    for (int k = 0; k < 5; k++) pk.push_back(rand_beat());
    send_pkt(pk);
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd0, 8'd12, 25'd0));
    for (int k = 0; k < 8; k++) pk.push_back(rand_beat());
    send_pkt(pk);

    // Action header with an out-of-range address.
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd1, 8'd16, 25'h0123456));
    send_pkt(pk);

    // Reset on beat 4 of a CAM packet. Data beats carry stage nibble 0xA so
    // the leftover beats, replayed after reset, read as a foreign header.
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd0, 8'd7, 25'd0));
    for (int k = 0; k < 8; k++) begin
      b = rand_beat(); b[3:0] = 4'hA; pk.push_back(b);
    end
    send_beat(pk[0], 1'b0);
    send_beat(pk[1], 1'b0);
    send_beat(pk[2], 1'b0);
    @(negedge clk);
    tdata  = pk[3];
    tvalid = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    check_reset_outputs("mid_pkt_reset");
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_wr  = 0;
    exp_err = 0;
    exp_q.delete();
    stale.delete();
    for (int k = 4; k < 9; k++) stale.push_back(pk[k]);
    send_pkt(stale);
    pk.delete();
    pk.push_back(mk_hdr(4'd2, 4'd1, 8'd3, 25'h0055AA1));
    send_pkt(pk);

    // Randomised mix of good, foreign and malformed packets.
    for (int p = 0; p < 60; p++) begin
      stg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : STAGE;
      r   = $urandom_range(0, 9);
      typ = (r < 5) ? 0 : (r < 9) ? 1 : int'($urandom_range(2, 15));
      adr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 255))
                                        : int'($urandom_range(0, 15));
      if (typ == 0) n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 9;
      else          n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 1;
      pk.delete();
      pk.push_back(mk_hdr(4'(stg), 4'(typ), 8'(adr), 25'($urandom)));
      for (int k = 1; k < n; k++) pk.push_back(rand_beat());
      send_pkt(pk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
